pipe_hazard_ctrl: RTL and testbench

//  Hazard controller for the 5-stage ARM pipe; the control side of the pipe registers (pipeDeco/Exe/Mem/WB).

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/hazard_fwd_sel.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;
    localparam int SB_AW = 4;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [SB_AW-1:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {RUN, LOADUSE, MEMWAIT} hz_state_t;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] wa;
        logic             regwrite;
        logic             memtoreg;
    } sb_slot_t;

    // R15 reads as PC+8, so it can never depend on an in-flight writer.
    function automatic logic src_hit(logic [SB_AW-1:0] ra, logic used, sb_slot_t slot);
        return used && (ra != REG_PC) && slot.valid && slot.regwrite && (slot.wa == ra);
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - datapath <-> hazard controller signal bundle
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW   = 4,
    parameter int STALL_CW = 8
);
    logic [REG_AW-1:0]   RA1D;
    logic [REG_AW-1:0]   RA2D;
    logic [REG_AW-1:0]   WA3D;
    logic                Use1D;
    logic                Use2D;
    logic                RegWriteD;
    logic                MemToRegD;
    logic                BranchTakenE;
    logic                MemWaitM;
    logic                StallF;
    logic                StallD;
    logic                StallE;
    logic                StallM;
    logic                FlushD;
    logic                FlushE;
    logic [1:0]          ForwardAE;
    logic [1:0]          ForwardBE;
    logic [STALL_CW-1:0] stall_cnt;
    pipe_pkg::hz_state_t state;

    modport master (
        output RA1D, RA2D, WA3D, Use1D, Use2D, RegWriteD, MemToRegD, BranchTakenE, MemWaitM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, state
    );

    modport slave (
        input  RA1D, RA2D, WA3D, Use1D, Use2D, RegWriteD, MemToRegD, BranchTakenE, MemWaitM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, state
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - forwarding select for one execute-stage operand
module hazard_fwd_sel
    import pipe_pkg::*;
(
    input  logic [SB_AW-1:0] ra,
    input  logic             used,
    input  sb_slot_t         slot_m,
    input  sb_slot_t         slot_w,
    output logic [1:0]       sel
);
    // A load in M has no data yet; it is covered by the load-use stall and a later W forward.
    always_comb begin
        sel = FWD_RF;
        if (src_hit(ra, used, slot_m) && !slot_m.memtoreg) begin
            sel = FWD_M;
        end else if (src_hit(ra, used, slot_w)) begin
            sel = FWD_W;
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward control for the 5-stage pipe; HAZARD_FORWARD_EN enables forwarding
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int STALL_CW = 8
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [STALL_CW-1:0] CNT_MAX = '1;

    hz_state_t           state_q, state_next;
    sb_slot_t            slot_e, slot_m, slot_d;
    logic [STALL_CW-1:0] cnt_q, cnt_next;
    logic [REG_AW-1:0]   ra1_d, ra2_d, wa_d;
    logic                data_hz, stall_fd, stall_em, flush_d, flush_e;

    assign ra1_d  = hz.RA1D;
    assign ra2_d  = hz.RA2D;
    assign wa_d   = hz.WA3D;
    assign slot_d = '{valid: 1'b1, wa: wa_d, regwrite: hz.RegWriteD, memtoreg: hz.MemToRegD};

`ifdef HAZARD_FORWARD_EN
    sb_slot_t          slot_w;
    logic [REG_AW-1:0] e_ra1, e_ra2;
    logic              e_use1, e_use2;

    assign data_hz = slot_e.memtoreg &&
                     (src_hit(ra1_d, hz.Use1D, slot_e) || src_hit(ra2_d, hz.Use2D, slot_e));

    hazard_fwd_sel u_fwd_a (.ra(e_ra1), .used(e_use1), .slot_m(slot_m), .slot_w(slot_w), .sel(hz.ForwardAE));
    hazard_fwd_sel u_fwd_b (.ra(e_ra2), .used(e_use2), .slot_m(slot_m), .slot_w(slot_w), .sel(hz.ForwardBE));

    // W and the E source fields only matter as forwarding inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_w <= '0;
            e_ra1  <= '0;
            e_ra2  <= '0;
            e_use1 <= 1'b0;
            e_use2 <= 1'b0;
        end else if (!hz.MemWaitM) begin
            slot_w <= slot_m;
            e_ra1  <= flush_e ? '0 : ra1_d;
            e_ra2  <= flush_e ? '0 : ra2_d;
            e_use1 <= flush_e ? 1'b0 : hz.Use1D;
            e_use2 <= flush_e ? 1'b0 : hz.Use2D;
        end
    end
`else
    // Without forwarding, a source must wait until its writer reaches W (regfile writes on negedge).
    assign data_hz = src_hit(ra1_d, hz.Use1D, slot_e) || src_hit(ra2_d, hz.Use2D, slot_e) ||
                     src_hit(ra1_d, hz.Use1D, slot_m) || src_hit(ra2_d, hz.Use2D, slot_m);
    assign hz.ForwardAE = FWD_RF;
    assign hz.ForwardBE = FWD_RF;
`endif

    always_comb begin
        state_next = RUN;
        stall_fd   = 1'b0;
        stall_em   = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        if (hz.MemWaitM) begin
            stall_fd   = 1'b1;
            stall_em   = 1'b1;
            state_next = MEMWAIT;
        end else if (hz.BranchTakenE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (data_hz) begin
            stall_fd   = 1'b1;
            flush_e    = 1'b1;
            state_next = LOADUSE;
        end
    end

    // Shown combinationally so the first stall cycle already reads 1.
    assign cnt_next = stall_fd ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            slot_e  <= '0;
            slot_m  <= '0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            if (!hz.MemWaitM) begin
                slot_m <= slot_e;
                slot_e <= flush_e ? '0 : slot_d;
            end
        end
    end

    assign hz.StallF    = stall_fd;
    assign hz.StallD    = stall_fd;
    assign hz.StallE    = stall_em;
    assign hz.StallM    = stall_em;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.stall_cnt = cnt_next;
    assign hz.state     = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and random self-check of pipe_hazard_ctrl against a stage-list model
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    typedef struct {
        bit v;
        int wa;
        bit rw;
        bit mr;
        int ra1;
        int ra2;
        bit u1;
        bit u2;
    } instr_t;

    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;

    instr_t    st_e, st_m, st_w, cur, rnd;
    bit        cur_br, cur_mw;
    int        m_cnt;
    hz_state_t m_state;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(4), .STALL_CW(8)) hz ();
    pipe_hazard_ctrl #(.REG_AW(4), .STALL_CW(8)) dut (.clk(clk), .rst(rst), .hz(hz));

    function automatic instr_t mk(int wa, bit rw, bit mr, int ra1, bit u1, int ra2, bit u2);
        instr_t t;
        t.v = 1'b1; t.wa = wa; t.rw = rw; t.mr = mr;
        t.ra1 = ra1; t.u1 = u1; t.ra2 = ra2; t.u2 = u2;
        return t;
    endfunction

    function automatic instr_t bubble();
        instr_t t;
        t = '{default: 0};
        return t;
    endfunction

    function automatic instr_t quiet();
        return mk(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endfunction

    function automatic bit depends(int r, bit u, instr_t s);
        return u && (r != 15) && s.v && s.rw && (s.wa == r);
    endfunction

    function automatic int fwd_of(int r, bit u);
        if (!u || r == 15) return 0;
        if (st_m.v && st_m.rw && !st_m.mr && st_m.wa == r) return 2;
        if (st_w.v && st_w.rw && st_w.wa == r) return 1;
        return 0;
    endfunction

    function automatic int rreg();
        return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    endfunction

    task automatic chk(string tag, string what, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp);
        end
    endtask

    task automatic drive(instr_t d, bit br, bit mw);
        cur = d; cur_br = br; cur_mw = mw;
        hz.RA1D = 4'(d.ra1); hz.RA2D = 4'(d.ra2); hz.WA3D = 4'(d.wa);
        hz.Use1D = d.u1; hz.Use2D = d.u2;
        hz.RegWriteD = d.rw; hz.MemToRegD = d.mr;
        hz.BranchTakenE = br; hz.MemWaitM = mw;
    endtask

    task automatic model_reset();
        st_e = bubble(); st_m = bubble(); st_w = bubble();
        m_cnt = 0; m_state = RUN;
    endtask

    task automatic step(string tag);
        bit haz, sfd, sem, fd, fe;
        int fa, fb, ecnt;
        #1;
`ifdef HAZARD_FORWARD_EN
        haz = st_e.mr && (depends(cur.ra1, cur.u1, st_e) || depends(cur.ra2, cur.u2, st_e));
        fa = fwd_of(st_e.ra1, st_e.u1);
        fb = fwd_of(st_e.ra2, st_e.u2);
`else
        haz = depends(cur.ra1, cur.u1, st_e) || depends(cur.ra2, cur.u2, st_e) ||
              depends(cur.ra1, cur.u1, st_m) || depends(cur.ra2, cur.u2, st_m);
        fa = 0;
        fb = 0;
`endif
        sem  = cur_mw;
        sfd  = cur_mw || (!cur_br && haz);
        fd   = !cur_mw && cur_br;
        fe   = !cur_mw && (cur_br || haz);
        ecnt = sfd ? ((m_cnt >= 255) ? 255 : m_cnt + 1) : 0;
        chk(tag, "StallF", 32'(hz.StallF), 32'(sfd));
        chk(tag, "StallD", 32'(hz.StallD), 32'(sfd));
        chk(tag, "StallE", 32'(hz.StallE), 32'(sem));
        chk(tag, "StallM", 32'(hz.StallM), 32'(sem));
        chk(tag, "FlushD", 32'(hz.FlushD), 32'(fd));
        chk(tag, "FlushE", 32'(hz.FlushE), 32'(fe));
        chk(tag, "ForwardAE", 32'(hz.ForwardAE), 32'(fa));
        chk(tag, "ForwardBE", 32'(hz.ForwardBE), 32'(fb));
        chk(tag, "stall_cnt", 32'(hz.stall_cnt), 32'(ecnt));
        chk(tag, "state", 32'(hz.state), 32'(m_state));
        @(posedge clk);
        m_cnt = ecnt;
        if (cur_mw) m_state = MEMWAIT;
        else if (!cur_br && haz) m_state = LOADUSE;
        else m_state = RUN;
        if (!cur_mw) begin
            st_w = st_m;
            st_m = st_e;
            st_e = fe ? bubble() : cur;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(quiet(), 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        #1;
        chk("reset", "StallF", 32'(hz.StallF), 0);
        chk("reset", "FlushE", 32'(hz.FlushE), 0);
        chk("reset", "ForwardAE", 32'(hz.ForwardAE), 0);
        chk("reset", "stall_cnt", 32'(hz.stall_cnt), 0);
        chk("reset", "state", 32'(hz.state), 32'(RUN));
        step("reset");

`ifdef HAZARD_FORWARD_EN
        drive(mk(1, 1, 1, 0, 0, 0, 0), 0, 0); step("ldr_r1");
        drive(mk(2, 1, 0, 1, 1, 3, 1), 0, 0);
        #1;
        chk("loaduse", "StallF", 32'(hz.StallF), 1);
        chk("loaduse", "StallD", 32'(hz.StallD), 1);
        chk("loaduse", "FlushE", 32'(hz.FlushE), 1);
        step("loaduse");
        #1; chk("loaduse_retry", "StallF", 32'(hz.StallF), 0);
        step("loaduse_retry");
        drive(quiet(), 0, 0);
        #1; chk("loaduse_fwd", "ForwardAE", 32'(hz.ForwardAE), 1);
        step("loaduse_fwd");

        drive(mk(1, 1, 0, 2, 1, 3, 1), 0, 0); step("add_r1");
        drive(mk(4, 1, 0, 1, 1, 1, 1), 0, 0);
        #1; chk("alu_dep", "StallF", 32'(hz.StallF), 0);
        step("alu_dep");
        drive(quiet(), 0, 0);
        #1;
        chk("fwd_m", "ForwardAE", 32'(hz.ForwardAE), 2);
        chk("fwd_m", "ForwardBE", 32'(hz.ForwardBE), 2);
        step("fwd_m");
        drive(mk(1, 1, 0, 2, 1, 3, 1), 0, 0); step("add_r1b");
        drive(quiet(), 0, 0); step("gap");
        drive(mk(4, 1, 0, 1, 1, 1, 1), 0, 0); step("sub_gap");
        drive(quiet(), 0, 0);
        #1;
        chk("fwd_w", "ForwardAE", 32'(hz.ForwardAE), 1);
        chk("fwd_w", "ForwardBE", 32'(hz.ForwardBE), 1);
        step("fwd_w");
`else
        drive(mk(1, 1, 0, 2, 1, 3, 1), 0, 0); step("add_r1");
        drive(mk(2, 1, 0, 1, 1, 3, 1), 0, 0);
        #1; chk("raw_e", "StallF", 32'(hz.StallF), 1);
        step("raw_e");
        #1;
        chk("raw_m", "StallF", 32'(hz.StallF), 1);
        chk("raw_m", "stall_cnt", 32'(hz.stall_cnt), 2);
        step("raw_m");
        #1; chk("raw_done", "StallF", 32'(hz.StallF), 0);
        step("raw_done");
`endif

        drive(mk(1, 1, 1, 0, 0, 0, 0), 0, 0); step("br_ldr");
        drive(mk(2, 1, 0, 1, 1, 3, 1), 1, 0);
        #1;
        chk("branch", "FlushD", 32'(hz.FlushD), 1);
        chk("branch", "FlushE", 32'(hz.FlushE), 1);
        chk("branch", "StallD", 32'(hz.StallD), 0);
        step("branch");
        drive(mk(4, 1, 0, 2, 1, 2, 1), 0, 0);
        #1; chk("after_branch", "StallF", 32'(hz.StallF), 0);
        step("after_branch");

        drive(mk(5, 1, 0, 0, 0, 0, 0), 0, 0); step("add_r5");
        for (int k = 0; k < 5; k++) begin
            drive(quiet(), 0, 1);
            #1;
            chk("memwait", "stall_cnt", 32'(hz.stall_cnt), 32'(k + 1));
            chk("memwait", "StallM", 32'(hz.StallM), 1);
            step("memwait");
        end
        drive(quiet(), 0, 0);
        #1;
        chk("memwait_end", "stall_cnt", 32'(hz.stall_cnt), 0);
        chk("memwait_end", "StallF", 32'(hz.StallF), 0);
        step("memwait_end");
        drive(mk(6, 1, 0, 5, 1, 0, 0), 0, 0); step("r5_reader");
        drive(quiet(), 0, 0); step("r5_after");

        drive(mk(15, 1, 1, 0, 0, 0, 0), 0, 0); step("ldr_r15");
        drive(mk(3, 1, 0, 15, 1, 15, 1), 0, 0);
        #1;
        chk("pc_src", "StallF", 32'(hz.StallF), 0);
        chk("pc_src", "ForwardAE", 32'(hz.ForwardAE), 0);
        step("pc_src");
        drive(quiet(), 0, 0);
        #1; chk("pc_fwd", "ForwardAE", 32'(hz.ForwardAE), 0);
        step("pc_fwd");

        drive(mk(1, 1, 1, 0, 0, 0, 0), 0, 0); step("pre_rst_ldr");
        drive(mk(2, 1, 0, 1, 1, 3, 1), 0, 0); step("pre_rst_stall");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_rst", "state", 32'(hz.state), 32'(RUN));
        chk("mid_rst", "StallF", 32'(hz.StallF), 0);
        chk("mid_rst", "FlushE", 32'(hz.FlushE), 0);
        chk("mid_rst", "ForwardAE", 32'(hz.ForwardAE), 0);
        chk("mid_rst", "stall_cnt", 32'(hz.stall_cnt), 0);
        step("mid_rst");

        for (int k = 0; k < 260; k++) begin
            drive(quiet(), 0, 1);
            if (k == 259) begin
                #1; chk("saturate", "stall_cnt", 32'(hz.stall_cnt), 255);
            end
            step("saturate");
        end
        drive(quiet(), 0, 0); step("saturate_end");

        for (int k = 0; k < 400; k++) begin
            rnd = mk(rreg(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     rreg(), $urandom_range(0, 1) == 1, rreg(), $urandom_range(0, 1) == 1);
            drive(rnd, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
